// File: rtl/debounce_pkg.sv
// Shared types, default parameters and counter-width helpers for the
// debounce_bank input conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        REPEAT
    } hold_state_t;

    localparam int unsigned DEF_N_CH          = 4;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 1048576;
    localparam int unsigned DEF_HOLD_CYCLES   = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10000000;
    localparam bit          DEF_REPEAT_EN     = 1'b0;

    // Bits needed to hold values 0..max_count, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        int unsigned w;
        w = $clog2(max_count + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, consecutive-sample stability counter,
// and long-press / auto-repeat hold FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int unsigned SW = cnt_width(STABLE_CYCLES);
    localparam int unsigned HW = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [SW-1:0]          stab_cnt;
    logic                   accept;
    logic                   clean_nxt;

    hold_state_t            state;
    hold_state_t            state_nxt;
    logic [HW-1:0]          hcnt;
    logic [HW-1:0]          hcnt_nxt;
    logic                   hold_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        accept    = (s != clean) && (stab_cnt == STABLE_LAST);
        clean_nxt = accept ? s : clean;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
            clean    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            if ((s == clean) || accept) begin
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + SW'(1);
            end
            clean <= clean_nxt;
            rise  <= accept & s;
            fall  <= accept & ~s;
        end
    end

    // Hold FSM looks at the level clean is about to take, so its count starts
    // on the edge that raises clean and a release never coincides with hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            hold  <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        if (!clean_nxt) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = PRESS;
                    hcnt_nxt  = '0;
                end
                PRESS: begin
                    if (hcnt == HOLD_LAST) begin
                        state_nxt = REPEAT;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (!REPEAT_EN || (hcnt == REPEAT_LAST)) begin
                        hcnt_nxt = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        hold_nxt = 1'b0;
        if (clean_nxt) begin
            case (state)
                PRESS:   hold_nxt = (hcnt == HOLD_LAST);
                REPEAT:  hold_nxt = REPEAT_EN && (hcnt == REPEAT_LAST);
                default: hold_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button/switch conditioner: N_CH independent debounce_channel
// instances sharing one clock and asynchronous reset.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = DEF_REPEAT_EN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .clean(clean[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .hold (hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (auto-repeat on / off) driven by the
// same inputs and compared every cycle against a run-length / press-age model.
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int ST = 8;
    localparam int HC = 32;
    localparam int RC = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] clean_r, rise_r, fall_r, hold_r;
    logic [N-1:0] clean_o, rise_o, fall_o, hold_o;

    int checks = 0;
    int errors = 0;

    // Model: sampled-input history, consecutive-disagreement run length and
    // age of the current press in cycles since its rise pulse.
    logic [N-1:0] m_pipe [SS];
    logic [N-1:0] m_clean, m_rise, m_fall, m_hold_r, m_hold_o;
    int           m_run [N];
    int           m_age [N];

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(N), .SYNC_STAGES(SS), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk(clk), .rst(rst), .btn(btn),
        .clean(clean_r), .rise(rise_r), .fall(fall_r), .hold(hold_r)
    );

    debounce_bank #(
        .N_CH(N), .SYNC_STAGES(SS), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b0)
    ) dut_one (
        .clk(clk), .rst(rst), .btn(btn),
        .clean(clean_o), .rise(rise_o), .fall(fall_o), .hold(hold_o)
    );

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_pipe[i] = '0;
        m_clean = '0; m_rise = '0; m_fall = '0; m_hold_r = '0; m_hold_o = '0;
        for (int ch = 0; ch < N; ch++) begin
            m_run[ch] = 0;
            m_age[ch] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] b);
        logic [N-1:0] s;
        s = m_pipe[SS-1];
        m_rise = '0; m_fall = '0; m_hold_r = '0; m_hold_o = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (s[ch] != m_clean[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == ST) begin
                    m_run[ch]   = 0;
                    m_clean[ch] = s[ch];
                    m_rise[ch]  = s[ch];
                    m_fall[ch]  = ~s[ch];
                end
            end else begin
                m_run[ch] = 0;
            end
            if (!m_clean[ch] || m_rise[ch]) begin
                m_age[ch] = 0;
            end else begin
                m_age[ch]++;
                if (m_age[ch] >= HC) begin
                    m_hold_o[ch] = (m_age[ch] == HC);
                    m_hold_r[ch] = ((m_age[ch] - HC) % RC) == 0;
                end
            end
        end
        for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = b;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("clean_rep", clean_r, m_clean);
        check("rise_rep",  rise_r,  m_rise);
        check("fall_rep",  fall_r,  m_fall);
        check("hold_rep",  hold_r,  m_hold_r);
        check("clean_one", clean_o, m_clean);
        check("rise_one",  rise_o,  m_rise);
        check("fall_one",  fall_o,  m_fall);
        check("hold_one",  hold_o,  m_hold_o);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(btn);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // First tick is the sampling edge; n counts edges after it until rise.
    task automatic wait_rise(input int ch, output int n);
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!rise_r[ch] && n < 40);
    endtask

    task automatic wait_hold(input int ch, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!hold_r[ch] && n < 60);
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("reset_all_zero", clean_r | rise_r | fall_r | hold_r | clean_o | rise_o | fall_o | hold_o, '0);
        ticks(2);
        #3 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        int hold_at[$];
        int dur[N];

        model_reset();
        ticks(3);
        check("reset_clean", clean_r, '0);
        #3 rst = 1'b0;

        // Clean press on channel 0.
        btn[0] = 1'b1;
        wait_rise(0, n);
        check_int("press_latency", n, 9);
        check("press_rise_only_ch0", rise_r, 4'b0001);
        check("press_clean_only_ch0", clean_r, 4'b0001);

        // Bounce on channel 1, then settle high.
        for (int i = 0; i < 14; i++) begin
            btn[1] = ~btn[1];
            ticks(3);
            check_int("bounce_clean1_low", int'(clean_r[1]), 0);
        end
        btn[1] = 1'b1;
        wait_rise(1, n);
        check_int("bounce_settle_latency", n, 9);

        // Long hold with auto-repeat on channel 2.
        btn[2] = 1'b1;
        wait_rise(2, n);
        check_int("ch2_latency", n, 9);
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (hold_r[2]) hold_at.push_back(t);
        end
        check_int("repeat_count", hold_at.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check_int("repeat_time", (k < hold_at.size()) ? hold_at[k] : -1, HC + RC * k);
        end
        btn[2] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            cnt_a += int'(fall_r[2]);
            cnt_b += int'(hold_r[2]);
        end
        check_int("release_fall_count", cnt_a, 1);
        check_int("release_hold_count", cnt_b, 0);

        // Short and long press on channel 3, single-pulse instance.
        btn[3] = 1'b1;
        wait_rise(3, n);
        cnt_b = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            cnt_b += int'(hold_o[3]);
        end
        btn[3] = 1'b0;
        cnt_a = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            cnt_a += int'(fall_o[3]);
            cnt_b += int'(hold_o[3]);
        end
        check_int("short_fall_count", cnt_a, 1);
        check_int("short_hold_count", cnt_b, 0);
        btn[3] = 1'b1;
        wait_rise(3, n);
        cnt_b = 0;
        for (int t = 0; t < 80; t++) begin
            tick();
            cnt_b += int'(hold_o[3]);
        end
        check_int("long_single_hold_count", cnt_b, 1);

        btn = '0;
        ticks(20);
        check("all_released", clean_r, '0);

        // Simultaneous press on every channel.
        btn = '1;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (rise_r == '0 && n < 40);
        check_int("simul_latency", n, 9);
        check("simul_rise", rise_r, 4'b1111);
        btn = '0;
        ticks(20);

        // Reset five cycles into a debounce, then again during REPEAT.
        btn[0] = 1'b1;
        ticks(5);
        async_reset();
        wait_rise(0, n);
        check_int("post_reset_latency", n, 9);
        wait_hold(0, n);
        check_int("post_reset_hold", n, HC);
        ticks(20);
        check_int("in_repeat_clean", int'(clean_r[0]), 1);
        async_reset();
        wait_rise(0, n);
        check_int("post_repeat_reset_latency", n, 9);
        wait_hold(0, n);
        check_int("post_repeat_reset_hold", n, HC);
        btn = '0;
        ticks(20);

        // Randomised bouncing and presses, one reset along the way.
        for (int ch = 0; ch < N; ch++) dur[ch] = $urandom_range(1, 60);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    btn[ch] = ~btn[ch];
                    if ($urandom_range(0, 3) == 0) dur[ch] = $urandom_range(1, 6);
                    else                           dur[ch] = $urandom_range(10, 90);
                end else begin
                    dur[ch]--;
                end
            end
            tick();
            if (cyc == 700) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
